alu_cmd_dispatcher: RTL and testbench

ALU_CMD_DISPATCHER -- requirements
Module: alu_cmd_dispatcher

---
 rtl/alu_cmd_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_dispatcher.sv
// Command FIFO feeding a single ALU through an IDLE/NOOP/BUSY/RESP sequencer.
// Illegal opcodes are dropped with a one-cycle error pulse; stalled ALU ops time out.
module alu_cmd_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        err_illegal,
  output logic        err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, NOOP, BUSY, RESP} state_e;
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d, rsp_op_q, rsp_op_d;
  logic          alu_start_q, alu_start_d, rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic          err_illegal_q, err_illegal_d, err_timeout_q, err_timeout_d;
  logic          push, pop;

  assign cmd_ready = (count_q != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_start_d   = alu_start_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    err_illegal_d = 1'b0;
    err_timeout_d = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop = 1'b1;
        if (head.op > 3'd4) begin
          err_illegal_d = 1'b1;
        end else begin
          alu_a_d     = head.a;
          alu_b_d     = head.b;
          alu_op_d    = head.op;
          alu_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = (head.op == 3'd0) ? NOOP : BUSY;
        end
      end
      NOOP: begin
        alu_start_d = 1'b0;
        state_d     = IDLE;
      end
      // A done sampled on the final counted cycle still wins over the timeout.
      BUSY: if (alu_done) begin
        alu_start_d  = 1'b0;
        rsp_result_d = alu_result;
        rsp_op_d     = alu_op_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        alu_start_d   = 1'b0;
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_start   = alu_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Randomized bench: a transaction-level model (command queue + per-command outcome
// predicted from ALU latency) checks the dispatcher every cycle on the falling edge.
module tb_alu_cmd_dispatcher;
  localparam int DEPTH = 4, TIMEOUT = 16;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op, rsp_op;
  logic        alu_start, alu_done = 1'b0, rsp_valid, rsp_ready = 1'b0;
  logic [15:0] alu_result = '0, rsp_result;
  logic        err_illegal, err_timeout;

  always #5 clk = ~clk;

  alu_cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        cur, samp;
  int          total = 0, bad = 0;
  int          ph = 0, k = 0, lat = 0;   // ph: 0 free, 1 no-op, 2 ALU running, 3 response held
  int          force_lat = -1, rdy_mode = 0;
  bit          push_samp = 0, pend_pop = 0, rst_seen = 0, rdy_prev = 0;
  logic [15:0] exp_res = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_res(input cmd_t c);
    case (c.op)
      3'd1:    return 16'(c.a) + 16'(c.b);
      3'd2:    return {8'h00, c.a & c.b};
      3'd3:    return {8'h00, c.a ^ c.b};
      3'd4:    return 16'(c.a) * 16'(c.b);
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    bit   popped, exp_rv, exp_to;
    int   ph0;
    cmd_t f;
    exp_rv = 1'b0;
    exp_to = 1'b0;
    if (reset) begin
      q.delete();
      ph = 0; push_samp = 1'b0; pend_pop = 1'b0; rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_op", 32'(rsp_op), 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
      end
      ph0 = ph;
      case (ph)
        0: begin
          popped = err_illegal || alu_start;
          chk("pop_timing", 32'(popped), 32'(pend_pop));
          if (err_illegal && q.size() > 0) begin
            f = q.pop_front();
            chk("illegal_op", 32'(f.op >= 3'd5), 32'd1);
          end else if (alu_start && q.size() > 0) begin
            f = q.pop_front();
            cur = f;
            exp_res = ref_res(f);
            chk("issue_legal", 32'(f.op <= 3'd4), 32'd1);
            chk("issue_op", 32'(alu_op), 32'(f.op));
            chk("issue_a", 32'(alu_a), 32'(f.a));
            chk("issue_b", 32'(alu_b), 32'(f.b));
            k = 0;
            if (force_lat >= 0) lat = force_lat;
            else if ($urandom_range(0, 3) == 0) lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else lat = $urandom_range(0, 5);
            ph = (f.op == 3'd0) ? 1 : 2;
          end
        end
        1: begin
          chk("noop_start_fall", 32'(alu_start), 32'd0);
          ph = 0;
        end
        2: begin
          if (k == lat) begin
            exp_rv = 1'b1;
            chk("done_start_fall", 32'(alu_start), 32'd0);
            chk("rsp_result", 32'(rsp_result), 32'(exp_res));
            chk("rsp_op", 32'(rsp_op), 32'(cur.op));
            ph = 3;
          end else if (k == TIMEOUT - 1) begin
            exp_to = 1'b1;
            chk("tmo_start_fall", 32'(alu_start), 32'd0);
            ph = 0;
          end else begin
            chk("busy_start", 32'(alu_start), 32'd1);
            chk("busy_a", 32'(alu_a), 32'(cur.a));
            chk("busy_b", 32'(alu_b), 32'(cur.b));
            chk("busy_op", 32'(alu_op), 32'(cur.op));
            k++;
          end
        end
        default: begin
          if (rdy_prev) ph = 0;
          else begin
            exp_rv = 1'b1;
            chk("resp_no_start", 32'(alu_start), 32'd0);
            chk("resp_hold_result", 32'(rsp_result), 32'(exp_res));
            chk("resp_hold_op", 32'(rsp_op), 32'(cur.op));
          end
        end
      endcase
      if (ph0 != 0) chk("err_illegal_quiet", 32'(err_illegal), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("err_timeout", 32'(err_timeout), 32'(exp_to));
      if (push_samp) q.push_back(samp);
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() != DEPTH));
      pend_pop  = (ph == 0) && (q.size() > 0);
      push_samp = cmd_valid && cmd_ready;
      samp.op = cmd_op; samp.a = cmd_a; samp.b = cmd_b;
    end
    // ALU and downstream behaviour for the coming cycle; stray dones probe the ignore rule
    if (!reset && ph == 2) begin
      alu_done   = (k == lat);
      alu_result = (k == lat) ? exp_res : 16'($urandom);
    end else begin
      alu_done   = ($urandom_range(0, 3) == 0);
      alu_result = 16'($urandom);
    end
    rsp_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
    rdy_prev  = rsp_ready;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        chk("push_wait", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // add 5+3 with done in the third ALU cycle
    rdy_mode = 1; force_lat = 2;
    push(3'b001, 8'h05, 8'h03);
    idle(15);

    // illegal op dropped, then xor
    push(3'b110, 8'h12, 8'h34);
    push(3'b011, 8'hFF, 8'h0F);
    idle(15);

    // no-op followed by and
    push(3'b000, 8'hAA, 8'h55);
    push(3'b010, 8'hF0, 8'h3C);
    idle(15);

    // stuck ALU: FIFO fills, every mul times out
    force_lat = 1000; rdy_mode = 0;
    for (int i = 0; i < 5; i++) push(3'b100, 8'($urandom), 8'($urandom));
    idle(5 * TIMEOUT + 30);

    // downstream stalls with a command waiting behind
    force_lat = 0; rdy_mode = 2;
    push(3'b001, 8'h7F, 8'h01);
    push(3'b100, 8'h10, 8'h10);
    idle(12);
    rdy_mode = 1;
    idle(30);

    // random traffic
    force_lat = -1; rdy_mode = 0;
    repeat (800) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 3'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (ph == 0 && q.size() == 0 && !push_samp) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'd1);

    // reset while the ALU is busy with two commands queued
    force_lat = 1000;
    for (int i = 0; i < 3; i++) push(3'b100, 8'(i + 1), 8'h02);
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (alu_start) begin
        done = 1'b1;
        break;
      end
    end
    chk("busy_before_reset", 32'(done), 32'd1);
    idle(3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
